// File: rtl/alu_seq64_if.sv
// alu_seq64 bus: request/response side plus the shared 32-bit ALU side.
// Width32 only exists when ALU_SEQ_BYPASS32_EN is defined.
interface alu_seq64_if;
    logic        Start;
    logic [1:0]  Op;
    logic [63:0] OpA;
    logic [63:0] OpB;
`ifdef ALU_SEQ_BYPASS32_EN
    logic        Width32;
`endif
    logic        Busy;
    logic        Done;
    logic [63:0] Result;
    logic [3:0]  Flags;
    logic [31:0] Src_A;
    logic [31:0] Src_B;
    logic        C_Flag;
    logic        shifter_carry_out;
    logic [3:0]  ALUControl;
    logic [31:0] ALUResult;
    logic [3:0]  ALUFlags;

    modport slave (
`ifdef ALU_SEQ_BYPASS32_EN
        input  Width32,
`endif
        input  Start, Op, OpA, OpB, ALUResult, ALUFlags,
        output Busy, Done, Result, Flags,
        output Src_A, Src_B, C_Flag, shifter_carry_out, ALUControl
    );

    modport master (
`ifdef ALU_SEQ_BYPASS32_EN
        output Width32,
`endif
        output Start, Op, OpA, OpB, ALUResult, ALUFlags,
        input  Busy, Done, Result, Flags,
        input  Src_A, Src_B, C_Flag, shifter_carry_out, ALUControl
    );
endinterface

// File: rtl/alu_seq64.sv
// 64-bit ADD/SUB/RSB/CMP sequencer driving a shared 32-bit ALU in two passes.
// Optional ALU_SEQ_BYPASS32_EN adds a single-pass 32-bit mode (Width32).
module alu_seq64 #(
    parameter bit DONE_STICKY = 1'b0
) (
    input logic CLK,
    input logic RESET,
    alu_seq64_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LO, HI, FIN} state_t;

    state_t      state;
    logic [31:0] a_hi, b_hi;
    logic [1:0]  op_q;
    logic        w32_q;
    logic [31:0] lo_res;
    logic        lo_c, lo_z;

    logic        busy_q, done_q, c_flag_q;
    logic [63:0] result_q;
    logic [3:0]  flags_q, ctl_q;
    logic [31:0] src_a_q, src_b_q;
    logic        w32_in;

`ifdef ALU_SEQ_BYPASS32_EN
    assign w32_in = bus.Width32;
`else
    assign w32_in = 1'b0;
`endif

    // Low-pass opcode; the high pass is the same code with the carry-in bit set.
    function automatic logic [3:0] base_ctl(input logic [1:0] op);
        case (op)
            2'b00:   base_ctl = 4'b0000;
            2'b10:   base_ctl = 4'b1000;
            default: base_ctl = 4'b0010;
        endcase
    endfunction

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            a_hi     <= '0;
            b_hi     <= '0;
            op_q     <= '0;
            w32_q    <= 1'b0;
            lo_res   <= '0;
            lo_c     <= 1'b0;
            lo_z     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            src_a_q  <= '0;
            src_b_q  <= '0;
            c_flag_q <= 1'b0;
            ctl_q    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.Start) begin
                        state    <= LO;
                        a_hi     <= bus.OpA[63:32];
                        b_hi     <= bus.OpB[63:32];
                        op_q     <= bus.Op;
                        w32_q    <= w32_in;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        src_a_q  <= bus.OpA[31:0];
                        src_b_q  <= bus.OpB[31:0];
                        c_flag_q <= 1'b0;
                        ctl_q    <= base_ctl(bus.Op);
                    end
                end
                LO: begin
                    lo_res <= bus.ALUResult;
                    lo_c   <= bus.ALUFlags[1];
                    lo_z   <= bus.ALUFlags[2];
                    if (w32_q) begin
                        state    <= FIN;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        flags_q  <= bus.ALUFlags;
                        if (op_q != 2'b11)
                            result_q <= {32'h0, bus.ALUResult};
                        src_a_q  <= '0;
                        src_b_q  <= '0;
                        c_flag_q <= 1'b0;
                        ctl_q    <= '0;
                    end else begin
                        state    <= HI;
                        src_a_q  <= a_hi;
                        src_b_q  <= b_hi;
                        c_flag_q <= bus.ALUFlags[1];
                        ctl_q    <= base_ctl(op_q) | 4'b0001;
                    end
                end
                HI: begin
                    state    <= FIN;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    flags_q  <= {bus.ALUFlags[3],
                                 bus.ALUFlags[2] & lo_z,
                                 bus.ALUFlags[1],
                                 bus.ALUFlags[0]};
                    if (op_q != 2'b11)
                        result_q <= {bus.ALUResult, lo_res};
                    src_a_q  <= '0;
                    src_b_q  <= '0;
                    c_flag_q <= 1'b0;
                    ctl_q    <= '0;
                end
                FIN: begin
                    state <= IDLE;
                    if (!DONE_STICKY)
                        done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Busy              = busy_q;
    assign bus.Done              = done_q;
    assign bus.Result            = result_q;
    assign bus.Flags             = flags_q;
    assign bus.Src_A             = src_a_q;
    assign bus.Src_B             = src_b_q;
    assign bus.C_Flag            = c_flag_q;
    assign bus.shifter_carry_out = 1'b0;
    assign bus.ALUControl        = ctl_q;
endmodule

// File: tb/tb_alu_seq64.sv
// Bench for alu_seq64: 32-bit ALU model, 64-bit reference model, directed and random ops.
// Build with ALU_SEQ_BYPASS32_EN to also exercise the 32-bit bypass.
module tb_alu_seq64;
    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic armed = 1'b0;

    alu_seq64_if bus();

    alu_seq64 dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus.slave)
    );

    always #5 CLK = ~CLK;

    // Shared 32-bit ALU: x + y + ci with operands chosen by ALUControl.
    logic [31:0] ax, ay;
    logic        aci;
    logic [32:0] as;
    always_comb begin
        ax  = bus.Src_A;
        ay  = bus.Src_B;
        aci = 1'b0;
        case (bus.ALUControl)
            4'b0001: aci = bus.C_Flag;
            4'b0010: begin ay = ~bus.Src_B; aci = 1'b1; end
            4'b0011: begin ay = ~bus.Src_B; aci = bus.C_Flag; end
            4'b1000: begin ax = bus.Src_B; ay = ~bus.Src_A; aci = 1'b1; end
            4'b1001: begin ax = bus.Src_B; ay = ~bus.Src_A; aci = bus.C_Flag; end
            default: ;
        endcase
        as = {1'b0, ax} + {1'b0, ay} + {32'h0, aci};
        bus.ALUResult = as[31:0];
        bus.ALUFlags  = {as[31], as[31:0] == 32'h0, as[32],
                         (ax[31] == ay[31]) && (as[31] != ax[31])};
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Whole-operation reference: returns {result, NZCV}.
    function automatic logic [67:0] calc(input logic [1:0] op, input logic [63:0] a,
                                         input logic [63:0] b, input logic w);
        logic [63:0] x, y, r;
        logic [64:0] s;
        logic [32:0] s32;
        logic [3:0]  f;
        logic        ci;
        x = a; y = b; ci = 1'b0;
        if (op == 2'b10) begin x = b; y = ~a; ci = 1'b1; end
        else if (op != 2'b00) begin y = ~b; ci = 1'b1; end
        if (w) begin
            s32 = {1'b0, x[31:0]} + {1'b0, y[31:0]} + {32'h0, ci};
            r = {32'h0, s32[31:0]};
            f = {s32[31], s32[31:0] == 32'h0, s32[32],
                 (x[31] == y[31]) && (s32[31] != x[31])};
        end else begin
            s = {1'b0, x} + {1'b0, y} + {64'h0, ci};
            r = s[63:0];
            f = {r[63], r == 64'h0, s[64], (x[63] == y[63]) && (r[63] != x[63])};
        end
        return {r, f};
    endfunction

    function automatic logic lo_carry(input logic [1:0] op, input logic [63:0] a,
                                      input logic [63:0] b);
        logic [32:0] s;
        if (op == 2'b00)      s = {1'b0, a[31:0]} + {1'b0, b[31:0]};
        else if (op == 2'b10) s = {1'b0, b[31:0]} + {1'b0, ~a[31:0]} + 33'd1;
        else                  s = {1'b0, a[31:0]} + {1'b0, ~b[31:0]} + 33'd1;
        return s[32];
    endfunction

    function automatic logic [3:0] ctl_of(input logic [1:0] op);
        return (op == 2'b00) ? 4'b0000 : (op == 2'b10) ? 4'b1000 : 4'b0010;
    endfunction

    logic w_in;
`ifdef ALU_SEQ_BYPASS32_EN
    assign w_in = bus.Width32;
`else
    assign w_in = 1'b0;
`endif

    // Model: phase counts cycles since accept (0 idle, 1 low, 2 high, 3 done).
    int unsigned m_ph = 0;
    logic [63:0] m_a, m_b, m_res;
    logic [1:0]  m_op;
    logic        m_w;
    logic [3:0]  m_flg;
    logic [67:0] m_calc;
    assign m_calc = calc(m_op, m_a, m_b, m_w);

    always @(posedge CLK) begin
        if (RESET) begin
            armed <= 1'b1;
            m_ph  <= 0;
            m_res <= '0;
            m_flg <= '0;
        end else begin
            case (m_ph)
                0: if (bus.Start) begin
                    m_a <= bus.OpA; m_b <= bus.OpB; m_op <= bus.Op; m_w <= w_in;
                    m_ph <= 1;
                end
                1: if (m_w) begin
                    if (m_op != 2'b11) m_res <= m_calc[67:4];
                    m_flg <= m_calc[3:0];
                    m_ph <= 3;
                end else m_ph <= 2;
                2: begin
                    if (m_op != 2'b11) m_res <= m_calc[67:4];
                    m_flg <= m_calc[3:0];
                    m_ph <= 3;
                end
                default: m_ph <= 0;
            endcase
        end
    end

    always @(negedge CLK) begin
        if (armed) begin
            chk("busy", {63'h0, bus.Busy}, {63'h0, (m_ph == 1 || m_ph == 2)});
            chk("done", {63'h0, bus.Done}, {63'h0, (m_ph == 3)});
            chk("result", bus.Result, m_res);
            chk("flags", {60'h0, bus.Flags}, {60'h0, m_flg});
            chk("src_a", {32'h0, bus.Src_A},
                (m_ph == 1) ? {32'h0, m_a[31:0]} : (m_ph == 2) ? {32'h0, m_a[63:32]} : 64'h0);
            chk("src_b", {32'h0, bus.Src_B},
                (m_ph == 1) ? {32'h0, m_b[31:0]} : (m_ph == 2) ? {32'h0, m_b[63:32]} : 64'h0);
            chk("ctl", {60'h0, bus.ALUControl},
                (m_ph == 1) ? {60'h0, ctl_of(m_op)} :
                (m_ph == 2) ? {60'h0, ctl_of(m_op) | 4'b0001} : 64'h0);
            chk("c_flag", {63'h0, bus.C_Flag},
                (m_ph == 2) ? {63'h0, lo_carry(m_op, m_a, m_b)} : 64'h0);
            chk("shc", {63'h0, bus.shifter_carry_out}, 64'h0);
        end
    end

    task automatic set_w(input logic w);
`ifdef ALU_SEQ_BYPASS32_EN
        bus.Width32 = w;
`else
        if (w) $display("note: Width32 ignored");
`endif
    endtask

    logic [3:0] hi_ctl;
    logic       hi_c;

    task automatic do_op(input string nm, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic w, input logic [63:0] er,
                         input logic [3:0] ef, input int elat);
        int k;
        @(negedge CLK);
        bus.Start = 1'b1; bus.Op = op; bus.OpA = a; bus.OpB = b; set_w(w);
        @(negedge CLK);
        bus.Start = 1'b0; bus.OpA = {$urandom, $urandom}; bus.OpB = {$urandom, $urandom};
        k = 1;
        while (!bus.Done && k < 10) begin
            @(negedge CLK);
            k++;
            if (k == 2) begin hi_ctl = bus.ALUControl; hi_c = bus.C_Flag; end
        end
        chk({nm, "_lat"}, 64'(k), 64'(elat));
        chk({nm, "_res"}, bus.Result, er);
        chk({nm, "_flg"}, {60'h0, bus.Flags}, {60'h0, ef});
    endtask

    initial begin
        int dn;
        bus.Start = 1'b0; bus.Op = 2'b00; bus.OpA = '0; bus.OpB = '0;
        set_w(1'b0);
        repeat (2) @(negedge CLK);
        chk("rst_busy", {63'h0, bus.Busy}, 64'h0);
        chk("rst_res", bus.Result, 64'h0);
        chk("rst_ctl", {60'h0, bus.ALUControl}, 64'h0);
        RESET = 1'b0;

        do_op("add_carry", 2'b00, 64'h00000000_FFFFFFFF, 64'h1, 1'b0,
              64'h00000001_00000000, 4'b0000, 3);
        chk("add_hi_ctl", {60'h0, hi_ctl}, 64'h1);
        chk("add_hi_c", {63'h0, hi_c}, 64'h1);
        do_op("add_ovf", 2'b00, 64'h7FFFFFFF_FFFFFFFF, 64'h1, 1'b0,
              64'h80000000_00000000, 4'b1001, 3);
        do_op("sub_eq", 2'b01, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 1'b0,
              64'h0, 4'b0110, 3);
        do_op("sub_neg", 2'b01, 64'h0, 64'h1, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 4'b1000, 3);
        do_op("rsb", 2'b10, 64'h1, 64'h1_00000000, 1'b0, 64'h00000000_FFFFFFFF, 4'b0010, 3);
        do_op("cmp", 2'b11, 64'h5, 64'h5, 1'b0, 64'h00000000_FFFFFFFF, 4'b0110, 3);
`ifdef ALU_SEQ_BYPASS32_EN
        do_op("w32_add", 2'b00, 64'hFFFFFFFF, 64'h1, 1'b1, 64'h0, 4'b0110, 2);
        set_w(1'b0);
`endif

        // Start repeated during LO and HI must be ignored.
        @(negedge CLK);
        bus.Start = 1'b1; bus.Op = 2'b00; bus.OpA = 64'h1; bus.OpB = 64'h2;
        dn = 0;
        @(negedge CLK); bus.Op = 2'b01; bus.OpA = 64'd100; bus.OpB = 64'd7;
        @(negedge CLK); bus.OpA = 64'd55;
        for (int i = 0; i < 7; i++) begin
            if (bus.Done) dn++;
            bus.Start = 1'b0;
            @(negedge CLK);
        end
        chk("ign_done_cnt", 64'(dn), 64'd1);
        chk("ign_res", bus.Result, 64'd3);

        // Reset during HI abandons the op.
        @(negedge CLK);
        bus.Start = 1'b1; bus.Op = 2'b00; bus.OpA = 64'h10; bus.OpB = 64'h20;
        @(negedge CLK); bus.Start = 1'b0;
        @(negedge CLK); RESET = 1'b1;
        @(negedge CLK); RESET = 1'b0;
        chk("rhi_busy", {63'h0, bus.Busy}, 64'h0);
        chk("rhi_done", {63'h0, bus.Done}, 64'h0);
        chk("rhi_res", bus.Result, 64'h0);
        chk("rhi_flg", {60'h0, bus.Flags}, 64'h0);
        dn = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (bus.Done) dn++;
        end
        chk("rhi_nodone", 64'(dn), 64'd0);

        for (int i = 0; i < 600; i++) begin
            @(negedge CLK);
            RESET = ($urandom_range(0, 80) == 0);
            bus.Start = ($urandom_range(0, 2) == 0);
            bus.Op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: begin bus.OpA = {$urandom, 32'hFFFFFFFF}; bus.OpB = 64'(1); end
                1: begin bus.OpA = 64'h8000_0000_0000_0000; bus.OpB = {$urandom, $urandom}; end
                default: begin bus.OpA = {$urandom, $urandom}; bus.OpB = {$urandom, $urandom}; end
            endcase
`ifdef ALU_SEQ_BYPASS32_EN
            set_w(1'($urandom_range(0, 1)));
`endif
        end
        @(negedge CLK);
        RESET = 1'b0; bus.Start = 1'b0;
        repeat (6) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
